// File: rtl/gpo_pad_pkg.sv
// Shared types and constants for the GPO pad controller.
// State encoding, pad drive-configuration struct and the timer width helper.
package gpo_pad_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        BIAS  = 2'd2,
        APPLY = 2'd3
    } gpo_state_e;

    typedef struct packed {
        logic [1:0] ds;
        logic       sr;
        logic       co;
        logic       odp;
        logic       odn;
    } pad_cfg_t;

    localparam pad_cfg_t PAD_CFG_RST = '0;

    // One timer serves both waits, so it must be wide enough for the larger one.
    function automatic int timerWidth(input int a, input int b);
        int wa;
        int wb;
        wa = $clog2(a);
        wb = $clog2(b);
        if (wb > wa) wa = wb;
        if (wa < 1) wa = 1;
        return wa;
    endfunction

endpackage

// File: rtl/gpo_pad_timer.sv
// Saturating load/decrement down-counter with a zero flag.
// Load has priority over decrement; the count never wraps below zero.
module gpo_pad_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gpo_pad_ctrl.sv
// GPO pad controller: safe drive-strength reconfiguration with bias supervision.
// Optional one-shot inverted pulse on pad_do_o when GPO_PULSE_EN is defined.
module gpo_pad_ctrl
    import gpo_pad_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int BIAS_TO_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dout,
    input  logic       oe_req,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_ds,
    input  logic       cfg_sr,
    input  logic       cfg_co,
    input  logic       cfg_odp,
    input  logic       cfg_odn,
    input  logic       vbias_ok,
    output logic       pad_do_o,
    output logic       pad_oe_o,
    output logic       pad_sr_o,
    output logic       pad_co_o,
    output logic       pad_odp_o,
    output logic       pad_odn_o,
    output logic [1:0] pad_ds_o,
    output logic       busy,
    output logic       bias_err
`ifdef GPO_PULSE_EN
    ,
    input  logic       pulse_start,
    input  logic [7:0] pulse_len
`endif
);

    localparam int            TW         = timerWidth(SETTLE_CYC, BIAS_TO_CYC);
    localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] BIAS_LD    = TW'(BIAS_TO_CYC - 1);

    gpo_state_e state_q;
    pad_cfg_t   cfgLat_q;
    pad_cfg_t   padCfg_q;
    pad_cfg_t   cfgIn;
    pad_cfg_t   biasFallback;
    logic       padDo_q;
    logic       padOe_q;
    logic       biasErr_q;
    logic       doNext;
    logic       accept;
    logic       runFault;
    logic       needBias;
    logic       timerLoad;
    logic       timerDec;
    logic       timerZero;
    logic [TW-1:0] timerLoadVal;

    assign cfgIn    = {cfg_ds, cfg_sr, cfg_co, cfg_odp, cfg_odn};
    assign accept   = (state_q == RUN) && cfg_valid;
    assign runFault = (padCfg_q.ds != 2'b00) && !vbias_ok;
    assign needBias = (cfgLat_q.ds != 2'b00) && !vbias_ok;

    always_comb begin
        biasFallback    = cfgLat_q;
        biasFallback.ds = 2'b00;
    end

    assign timerLoad    = accept || ((state_q == DRAIN) && timerZero && needBias);
    assign timerLoadVal = (state_q == RUN) ? SETTLE_LD : BIAS_LD;
    assign timerDec     = (state_q == DRAIN) || (state_q == BIAS);

    gpo_pad_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timerLoad),
        .loadVal_i (timerLoadVal),
        .dec_i     (timerDec),
        .zero_o    (timerZero)
    );

`ifdef GPO_PULSE_EN
    logic [7:0] pulseCnt_q;
    logic [7:0] pulseCnt_d;

    // Accepting a configuration (entering DRAIN) cancels any running pulse.
    always_comb begin
        pulseCnt_d = pulseCnt_q;
        if ((state_q != RUN) || cfg_valid) begin
            pulseCnt_d = '0;
        end else if (pulse_start && (pulse_len != 8'd0)) begin
            pulseCnt_d = pulse_len;
        end else if (pulseCnt_q != 8'd0) begin
            pulseCnt_d = pulseCnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulseCnt_q <= '0;
        end else begin
            pulseCnt_q <= pulseCnt_d;
        end
    end

    assign doNext = dout ^ (pulseCnt_d != 8'd0);
`else
    assign doNext = dout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cfgLat_q  <= PAD_CFG_RST;
            padCfg_q  <= PAD_CFG_RST;
            padDo_q   <= 1'b0;
            padOe_q   <= 1'b0;
            biasErr_q <= 1'b0;
        end else begin
            padDo_q <= doNext;
            case (state_q)
                RUN: begin
                    if (cfg_valid) begin
                        state_q   <= DRAIN;
                        cfgLat_q  <= cfgIn;
                        padOe_q   <= 1'b0;
                        biasErr_q <= runFault;
                    end else begin
                        padOe_q <= oe_req && !runFault;
                        if (runFault) biasErr_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    padOe_q <= 1'b0;
                    if (timerZero) begin
                        if (needBias) begin
                            state_q <= BIAS;
                        end else begin
                            state_q  <= APPLY;
                            padCfg_q <= cfgLat_q;
                        end
                    end
                end
                BIAS: begin
                    padOe_q <= 1'b0;
                    if (vbias_ok) begin
                        state_q  <= APPLY;
                        padCfg_q <= cfgLat_q;
                    end else if (timerZero) begin
                        state_q   <= APPLY;
                        cfgLat_q  <= biasFallback;
                        padCfg_q  <= biasFallback;
                        biasErr_q <= 1'b1;
                    end
                end
                APPLY: begin
                    state_q <= RUN;
                    padOe_q <= oe_req && !runFault;
                end
                default: begin
                    state_q <= RUN;
                    padOe_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = (state_q == RUN);
    assign busy      = (state_q != RUN);
    assign bias_err  = biasErr_q;
    assign pad_do_o  = padDo_q;
    assign pad_oe_o  = padOe_q;
    assign pad_ds_o  = padCfg_q.ds;
    assign pad_sr_o  = padCfg_q.sr;
    assign pad_co_o  = padCfg_q.co;
    assign pad_odp_o = padCfg_q.odp;
    assign pad_odn_o = padCfg_q.odn;

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Directed testbench for gpo_pad_ctrl with hand-computed expectations.
// Pulse checks are included when GPO_PULSE_EN is defined.
module tb_gpo_pad_ctrl;

    logic       clk;
    logic       rst;
    logic       dout;
    logic       oe_req;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ds;
    logic       cfg_sr;
    logic       cfg_co;
    logic       cfg_odp;
    logic       cfg_odn;
    logic       vbias_ok;
    logic       pad_do_o;
    logic       pad_oe_o;
    logic       pad_sr_o;
    logic       pad_co_o;
    logic       pad_odp_o;
    logic       pad_odn_o;
    logic [1:0] pad_ds_o;
    logic       busy;
    logic       bias_err;
`ifdef GPO_PULSE_EN
    logic       pulse_start;
    logic [7:0] pulse_len;
`endif

    int checkCount = 0;
    int failCount  = 0;

    gpo_pad_ctrl #(.SETTLE_CYC(4), .BIAS_TO_CYC(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .dout      (dout),
        .oe_req    (oe_req),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ds    (cfg_ds),
        .cfg_sr    (cfg_sr),
        .cfg_co    (cfg_co),
        .cfg_odp   (cfg_odp),
        .cfg_odn   (cfg_odn),
        .vbias_ok  (vbias_ok),
        .pad_do_o  (pad_do_o),
        .pad_oe_o  (pad_oe_o),
        .pad_sr_o  (pad_sr_o),
        .pad_co_o  (pad_co_o),
        .pad_odp_o (pad_odp_o),
        .pad_odn_o (pad_odn_o),
        .pad_ds_o  (pad_ds_o),
        .busy      (busy),
        .bias_err  (bias_err)
`ifdef GPO_PULSE_EN
        ,
        .pulse_start (pulse_start),
        .pulse_len   (pulse_len)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, then settle past it.
    task automatic applyStimulus(input logic d, input logic oe, input logic cv,
                                 input logic [1:0] ds, input logic vb);
        dout      = d;
        oe_req    = oe;
        cfg_valid = cv;
        cfg_ds    = ds;
        vbias_ok  = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] pattern;
        rst       = 1'b1;
        dout      = 1'b0;
        oe_req    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ds    = 2'b00;
        cfg_sr    = 1'b0;
        cfg_co    = 1'b0;
        cfg_odp   = 1'b0;
        cfg_odn   = 1'b0;
        vbias_ok  = 1'b1;
`ifdef GPO_PULSE_EN
        pulse_start = 1'b0;
        pulse_len   = 8'd0;
`endif
        #12;
        checkOutput("rst_ready", cfg_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_biaserr", bias_err, 0);
        checkOutput("rst_ds", pad_ds_o, 0);
        checkOutput("rst_oe", pad_oe_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pass-through: pad_do_o follows dout one edge later.
        pattern = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pattern[i], 1'b1, 1'b0, 2'b00, 1'b1);
            checkOutput("run_do", pad_do_o, pattern[i]);
            checkOutput("run_oe", pad_oe_o, 1);
        end
        checkOutput("run_ds", pad_ds_o, 0);

        // Reconfigure to DS=01 with bias present.
        cfg_sr  = 1'b1;
        cfg_odp = 1'b1;
        applyStimulus(0, 1, 1, 2'b01, 1);
        checkOutput("acc_ready", cfg_ready, 0);
        checkOutput("acc_busy", busy, 1);
        checkOutput("acc_oe", pad_oe_o, 0);
        applyStimulus(1, 1, 1, 2'b11, 1);
        checkOutput("drain_oe", pad_oe_o, 0);
        applyStimulus(0, 1, 0, 2'b01, 1);
        applyStimulus(0, 1, 0, 2'b01, 1);
        checkOutput("drain_ds", pad_ds_o, 2'b00);
        checkOutput("drain_ready", cfg_ready, 0);
        applyStimulus(0, 1, 0, 2'b01, 1);
        checkOutput("apply_ds", pad_ds_o, 2'b01);
        checkOutput("apply_oe", pad_oe_o, 0);
        checkOutput("apply_ready", cfg_ready, 0);
        checkOutput("apply_sr", pad_sr_o, 1);
        checkOutput("apply_odp", pad_odp_o, 1);
        checkOutput("apply_co", pad_co_o, 0);
        applyStimulus(0, 1, 0, 2'b01, 1);
        checkOutput("ret_oe", pad_oe_o, 1);
        checkOutput("ret_ready", cfg_ready, 1);
        checkOutput("ret_busy", busy, 0);
        checkOutput("ret_ds", pad_ds_o, 2'b01);

        // DS=11 with bias missing: timeout after 4 + 64 cycles falls back to DS=00.
        cfg_sr = 1'b0;
        applyStimulus(0, 1, 1, 2'b11, 1);
        checkOutput("bto_acc_err", bias_err, 0);
        for (int i = 1; i <= 67; i++) applyStimulus(0, 1, 0, 2'b11, 0);
        checkOutput("bto_wait_busy", busy, 1);
        checkOutput("bto_wait_ds", pad_ds_o, 2'b01);
        checkOutput("bto_wait_err", bias_err, 0);
        applyStimulus(0, 1, 0, 2'b11, 0);
        checkOutput("bto_ds", pad_ds_o, 2'b00);
        checkOutput("bto_err", bias_err, 1);
        checkOutput("bto_sr", pad_sr_o, 0);
        checkOutput("bto_oe", pad_oe_o, 0);
        applyStimulus(0, 1, 0, 2'b11, 0);
        checkOutput("bto_ready", cfg_ready, 1);
        checkOutput("bto_busy", busy, 0);
        checkOutput("bto_run_oe", pad_oe_o, 1);
        checkOutput("bto_sticky", bias_err, 1);

        // Accept clears bias_err; then bias drop in RUN with DS=10.
        applyStimulus(0, 1, 1, 2'b10, 1);
        checkOutput("clr_err", bias_err, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 2'b10, 1);
        checkOutput("ds10_ds", pad_ds_o, 2'b10);
        checkOutput("ds10_oe", pad_oe_o, 1);
        applyStimulus(0, 1, 0, 2'b10, 0);
        checkOutput("drop_oe", pad_oe_o, 0);
        checkOutput("drop_err", bias_err, 1);
        applyStimulus(0, 1, 0, 2'b10, 1);
        checkOutput("recov_oe", pad_oe_o, 1);
        checkOutput("recov_err", bias_err, 1);
        applyStimulus(0, 1, 1, 2'b10, 0);
        checkOutput("fault_wins", bias_err, 1);
        checkOutput("fault_ready", cfg_ready, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 2'b10, 1);
        checkOutput("fault_ret_ready", cfg_ready, 1);
        checkOutput("fault_ret_ds", pad_ds_o, 2'b10);

        // Reset mid-DRAIN discards the latched configuration.
        applyStimulus(0, 1, 1, 2'b11, 1);
        applyStimulus(0, 1, 0, 2'b11, 1);
        rst = 1'b1;
        #2;
        checkOutput("mid_rst_ready", cfg_ready, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_err", bias_err, 0);
        checkOutput("mid_rst_ds", pad_ds_o, 2'b00);
        checkOutput("mid_rst_oe", pad_oe_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 2'b00, 1);
        checkOutput("post_rst_ds", pad_ds_o, 2'b00);
        checkOutput("post_rst_do", pad_do_o, 1);
        checkOutput("post_rst_oe", pad_oe_o, 1);
        checkOutput("post_rst_ready", cfg_ready, 1);

`ifdef GPO_PULSE_EN
        // Five-cycle inverted pulse, then a zero-length request that does nothing.
        pulse_len   = 8'd5;
        pulse_start = 1'b1;
        applyStimulus(0, 1, 0, 2'b00, 1);
        pulse_start = 1'b0;
        checkOutput("pulse_1", pad_do_o, 1);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(0, 1, 0, 2'b00, 1);
            checkOutput("pulse_n", pad_do_o, 1);
        end
        applyStimulus(0, 1, 0, 2'b00, 1);
        checkOutput("pulse_end", pad_do_o, 0);
        pulse_len   = 8'd0;
        pulse_start = 1'b1;
        applyStimulus(0, 1, 0, 2'b00, 1);
        pulse_start = 1'b0;
        checkOutput("pulse_zero", pad_do_o, 0);
`endif

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gpo_pad_ctrl.md
GPO_PAD_CTRL -- requirements
Module: gpo_pad_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4, number of cycles (>=1) the pad output enable is held low before new drive settings are applied.
REQ-002 Parameter BIAS_TO_CYC, default 64, number of cycles (>=1) to wait for vbias_ok before falling back to DS=00.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 dout  in  1  core output data.
REQ-006 oe_req  in  1  core output-enable request.
REQ-007 cfg_valid  in  1  new drive-configuration request.
REQ-008 cfg_ready  out  1  configuration can be accepted.
REQ-009 cfg_ds  in  2  requested drive strength.
REQ-010 cfg_sr, cfg_co  in  1 each  requested slew-rate and CO settings.
REQ-011 cfg_odp, cfg_odn  in  1 each  requested open-drain high-side and low-side disables.
REQ-012 vbias_ok  in  1  pad bias-valid indication.
REQ-013 pad_do_o, pad_oe_o, pad_sr_o, pad_co_o, pad_odp_o, pad_odn_o  out  1 each  registered pad controls.
REQ-014 pad_ds_o  out  2  registered pad drive strength.
REQ-015 busy  out  1  reconfiguration sequence is in progress.
REQ-016 bias_err  out  1  sticky bias-fault flag.
REQ-017 pulse_start  in  1; pulse_len  in  8. Both ports exist only when GPO_PULSE_EN is defined.

Function
REQ-018 FSM states and transitions:
- RUN: cfg_ready=1, busy=0.
- DRAIN: entered on cfg_valid&&cfg_ready; cfg_* latched; pad_oe_o forced 0; SETTLE_CYC cycles.
- After DRAIN: go to BIAS if latched ds!=00 && !vbias_ok, otherwise go to APPLY.
- BIAS: go to APPLY on vbias_ok; after BIAS_TO_CYC cycles force latched ds=00, set bias_err, go to APPLY.
- APPLY: exactly one cycle; drives the latched settings with pad_oe_o=0; next state RUN.
REQ-019 cfg_ready=0 and busy=1 in DRAIN, BIAS and APPLY; cfg_valid is ignored in these states.
REQ-020 In RUN, pad_do_o and pad_oe_o follow dout and oe_req with exactly 1-cycle latency.
REQ-021 In RUN, pad_oe_o=0 whenever pad_ds_o!=00 and vbias_ok=0.
REQ-022 A vbias_ok drop in RUN while pad_ds_o!=00 sets bias_err on the next cycle.
REQ-023 pad_ds_o, pad_sr_o, pad_co_o, pad_odp_o and pad_odn_o change only in APPLY, never while pad_oe_o=1.
REQ-024 bias_err clears only on acceptance of a new configuration; a new fault in the same cycle wins.
REQ-025 The DRAIN counter and the BIAS timer are sized with $clog2 of their parameter and saturate; there is no wrap-around.

Reset
REQ-026 While rst=1:
- all pad_*_o = 0, including pad_ds_o=00;
- busy=0, bias_err=0, cfg_ready=1, state=RUN;
- counters cleared and any active pulse cancelled.
REQ-027 Reset asserted mid-DRAIN, mid-BIAS or mid-APPLY discards the latched configuration.

Configuration
REQ-028 Macro GPO_PULSE_EN, when defined, adds the one-shot pulse feature:
- in RUN, pulse_start with pulse_len=N>0 drives pad_do_o=~dout for N cycles;
- pulse_start during an active pulse reloads N;
- N=0 is ignored;
- entering DRAIN aborts the pulse.
REQ-029 Without GPO_PULSE_EN, the pulse ports and the pulse counter are absent and pad_do_o follows dout only.

Structure
REQ-030 Package gpo_pad_pkg holds:
- the state enum (RUN, DRAIN, BIAS, APPLY);
- the pad_cfg_t struct (ds, sr, co, odp, odn);
- the reset constant PAD_CFG_RST.
REQ-031 A single sub-module, gpo_pad_timer (load/decrement/zero-flag down-counter), is shared by the DRAIN and BIAS waits.

Verification
REQ-032 Reset then oe_req=1, dout toggling -> pad_do_o tracks dout 1 cycle later; pad_ds_o=00.
REQ-033 cfg_valid with cfg_ds=01, vbias_ok=1 -> pad_oe_o=0 for 4 cycles, DS=01 in APPLY, pad_oe_o=1 in cycle 6, cfg_ready low for 5 cycles.
REQ-034 cfg_ds=11, vbias_ok=0 for 100 cycles -> after 4+64 cycles pad_ds_o=00, bias_err=1, return to RUN.
REQ-035 vbias_ok falls in RUN with DS=10 -> pad_oe_o=0 and bias_err=1 next cycle; a later cfg accept clears bias_err.
REQ-036 rst pulsed mid-DRAIN -> all outputs at reset values, cfg_ready=1 immediately.
REQ-037 With GPO_PULSE_EN: dout=0, pulse_len=5 -> pad_do_o=1 for 5 cycles; pulse_len=0 -> no change.
